// File: rtl/conv_mac_stream_if.sv
// Bundle of the kernel-write, pixel-in and sum-out channels of conv_mac_stream.
// The master side drives kernel writes, pixel beats and out_ready. The slave side
// (the MAC block) returns k_err, in_ready, out_valid, out_data and busy.
interface conv_mac_stream_if #(
  parameter int DATA_W = 6,
  parameter int TAPS   = 9,
  parameter int ACC_W  = 2*DATA_W + $clog2(TAPS)
);
  localparam int ADDR_W = $clog2(TAPS);

  logic              k_we;
  logic [ADDR_W-1:0] k_addr;
  logic [DATA_W-1:0] k_data;
  logic              k_err;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;

  logic              busy;

  modport master (
    output k_we, k_addr, k_data, in_valid, in_data, out_ready,
    input  k_err, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  k_we, k_addr, k_data, in_valid, in_data, out_ready,
    output k_err, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/conv_mac_stream.sv
// Streaming convolution MAC. It multiplies TAPS pixel beats by TAPS stored
// kernel coefficients and presents one unsigned window sum per window. The
// coefficients can only be rewritten while no window is in flight.
module conv_mac_stream #(
  parameter int DATA_W = 6,
  parameter int TAPS   = 9,
  parameter int ACC_W  = 2*DATA_W + $clog2(TAPS)
) (
  input logic              clk,
  input logic              rst,
  conv_mac_stream_if.slave bus
);
  localparam int ADDR_W = $clog2(TAPS);
  localparam int PROD_W = 2*DATA_W;
  // The sum is formed at the wider of product and accumulator width, then
  // truncated. A narrowed ACC_W therefore wraps instead of saturating.
  localparam int SUM_W  = (ACC_W > PROD_W) ? ACC_W : PROD_W;
  localparam logic [ADDR_W:0]   TAPS_EXT = (ADDR_W+1)'(TAPS);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS-1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] coef [TAPS];
  logic [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0] tap_cnt;
  logic [ACC_W-1:0]  out_data_r;
  logic              k_err_r;

  logic              in_ready;
  logic              out_valid;
  logic              busy;
  logic              last_beat;
  logic              beat;
  logic              k_write_ok;
  logic [ADDR_W-1:0] coef_sel;
  logic [PROD_W-1:0] product;
  logic [SUM_W-1:0]  sum_full;
  logic [ACC_W-1:0]  acc_next;

  // State register; reset always lands in IDLE, abandoning any window in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs, all derived from the current state
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    last_beat  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (bus.in_valid && (tap_cnt == LAST_TAP)) begin
          last_beat  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign beat       = bus.in_valid && in_ready;
  assign k_write_ok = bus.k_we && (state == IDLE) && ({1'b0, bus.k_addr} < TAPS_EXT);

  // The first beat of a window always pairs with coef[0] and restarts the sum from zero
  assign coef_sel = (state == IDLE) ? '0 : tap_cnt;
  assign product  = PROD_W'(bus.in_data) * PROD_W'(coef[coef_sel]);
  assign sum_full = ((state == IDLE) ? '0 : SUM_W'(acc)) + SUM_W'(product);
  assign acc_next = sum_full[ACC_W-1:0];

  // Accumulator, tap counter and result register advance only on accepted beats
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      tap_cnt    <= '0;
      out_data_r <= '0;
    end else if (beat) begin
      if (last_beat) begin
        out_data_r <= acc_next;
        acc        <= '0;
        tap_cnt    <= '0;
      end else begin
        acc     <= acc_next;
        tap_cnt <= tap_cnt + 1'b1;
      end
    end
  end

  // Coefficient bank; written only in IDLE, so a running window never sees a change
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
    end else if (k_write_ok) begin
      coef[bus.k_addr] <= bus.k_data;
    end
  end

  // Flag a rejected kernel write for exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      k_err_r <= 1'b0;
    end else begin
      k_err_r <= bus.k_we && !k_write_ok;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.out_data  = out_data_r;
  assign bus.k_err     = k_err_r;
endmodule

// File: tb/tb_conv_mac_stream.sv
// Directed and table-driven bench for conv_mac_stream. The bench runs a 3x3
// 6-bit instance and a 5x5 8-bit instance, and compares every result against
// hand-computed values or a software reference sum.
module tb_conv_mac_stream;
  localparam int DATA_W  = 6;
  localparam int TAPS    = 9;
  localparam int ACC_W   = 2*DATA_W + $clog2(TAPS);
  localparam int BDATA_W = 8;
  localparam int BTAPS   = 25;
  localparam int BACC_W  = 2*BDATA_W + $clog2(BTAPS);

  typedef struct packed {
    logic [8:0][5:0] coef;
    logic [8:0][5:0] pix;
    logic [3:0]      gap;
    logic [15:0]     expected;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   check_cnt = 0;
  vec_t vecs [6];

  conv_mac_stream_if #(.DATA_W(DATA_W), .TAPS(TAPS)) bus ();
  conv_mac_stream_if #(.DATA_W(BDATA_W), .TAPS(BTAPS)) big_bus ();

  conv_mac_stream #(.DATA_W(DATA_W), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  conv_mac_stream #(.DATA_W(BDATA_W), .TAPS(BTAPS), .ACC_W(BACC_W)) dut_big (
    .clk (clk),
    .rst (rst),
    .bus (big_bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.k_we          = 1'b0;
    bus.k_addr        = '0;
    bus.k_data        = '0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.out_ready     = 1'b0;
    big_bus.k_we      = 1'b0;
    big_bus.k_addr    = '0;
    big_bus.k_data    = '0;
    big_bus.in_valid  = 1'b0;
    big_bus.in_data   = '0;
    big_bus.out_ready = 1'b0;
  endtask

  task automatic writeCoef(input int addr, input int data);
    bus.k_we   = 1'b1;
    bus.k_addr = 4'(addr);
    bus.k_data = 6'(data);
    tick();
    bus.k_we   = 1'b0;
  endtask

  task automatic applyStimulus(input int pix);
    bus.in_valid = 1'b1;
    bus.in_data  = 6'(pix);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Checks a pending sum, then drains it with a single out_ready cycle
  task automatic finishWindow(input string name, input int expected);
    checkOutput({name, "_valid"}, 32'(bus.out_valid), 1);
    checkOutput({name, "_sum"}, 32'(bus.out_data), 32'(expected));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput({name, "_drained"}, 32'(bus.out_valid), 0);
  endtask

  task automatic runVector(input vec_t v, input int idx);
    for (int n = 0; n < 9; n++) begin
      writeCoef(n, int'(v.coef[n]));
    end
    for (int n = 0; n < 9; n++) begin
      if (n > 0) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          tick();
          checkOutput($sformatf("vec%0d_gap_busy", idx), 32'(bus.busy), 1);
        end
      end
      if (n == 8) begin
        checkOutput($sformatf("vec%0d_early_valid", idx), 32'(bus.out_valid), 0);
      end
      applyStimulus(int'(v.pix[n]));
    end
    checkOutput($sformatf("vec%0d_in_ready_done", idx), 32'(bus.in_ready), 0);
    finishWindow($sformatf("vec%0d", idx), int'(v.expected));
    checkOutput($sformatf("vec%0d_idle_busy", idx), 32'(bus.busy), 0);
  endtask

  int unsigned bcoef [BTAPS];
  int unsigned bexp;
  int unsigned bpix;

  initial begin
    // Table of directed windows with hand-computed sums
    for (int n = 0; n < 9; n++) begin
      vecs[0].coef[n] = 6'd63;      vecs[0].pix[n] = 6'd63;
      vecs[1].coef[n] = 6'(n + 1);  vecs[1].pix[n] = 6'(n + 1);
      vecs[2].coef[n] = 6'd1;       vecs[2].pix[n] = 6'(n);
      vecs[3].coef[n] = 6'd0;       vecs[3].pix[n] = 6'd63;
      vecs[4].coef[n] = 6'(n);      vecs[4].pix[n] = 6'd63;
      vecs[5].coef[n] = 6'(9 - n);  vecs[5].pix[n] = 6'(n + 1);
    end
    vecs[0].gap = 4'd0; vecs[0].expected = 16'd35721;
    vecs[1].gap = 4'd2; vecs[1].expected = 16'd285;
    vecs[2].gap = 4'd0; vecs[2].expected = 16'd36;
    vecs[3].gap = 4'd1; vecs[3].expected = 16'd0;
    vecs[4].gap = 4'd1; vecs[4].expected = 16'd2268;
    vecs[5].gap = 4'd0; vecs[5].expected = 16'd165;

    // Reset state
    idleInputs();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_in_ready", 32'(bus.in_ready), 1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 0);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    checkOutput("reset_out_data", 32'(bus.out_data), 0);
    checkOutput("reset_k_err", 32'(bus.k_err), 0);
    checkOutput("reset_big_out_valid", 32'(big_bus.out_valid), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      runVector(vecs[i], i);
    end

    // DONE holds its result under backpressure and ignores pixel beats
    for (int n = 0; n < 9; n++) writeCoef(n, n + 1);
    for (int n = 0; n < 9; n++) applyStimulus(n + 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 6'd63;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("bp_out_data", 32'(bus.out_data), 285);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 0);
      checkOutput("bp_out_valid", 32'(bus.out_valid), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("bp_release_valid", 32'(bus.out_valid), 0);
    checkOutput("bp_release_busy", 32'(bus.busy), 0);
    for (int n = 0; n < 9; n++) applyStimulus(n + 1);
    finishWindow("bp_next", 285);

    // Rejected kernel writes: out-of-range address, and a write during a window
    bus.k_we   = 1'b1;
    bus.k_addr = 4'd9;
    bus.k_data = 6'd0;
    tick();
    bus.k_we = 1'b0;
    checkOutput("kerr_addr_pulse", 32'(bus.k_err), 1);
    tick();
    checkOutput("kerr_addr_clear", 32'(bus.k_err), 0);
    writeCoef(0, 1);
    checkOutput("kerr_good_write", 32'(bus.k_err), 0);
    applyStimulus(1);
    bus.k_we   = 1'b1;
    bus.k_addr = 4'd3;
    bus.k_data = 6'd0;
    tick();
    bus.k_we = 1'b0;
    checkOutput("kerr_accum_pulse", 32'(bus.k_err), 1);
    for (int n = 1; n < 9; n++) applyStimulus(n + 1);
    finishWindow("kerr_window", 285);
    for (int n = 0; n < 9; n++) applyStimulus(n + 1);
    finishWindow("kerr_coef_kept", 285);

    // Kernel write alongside the first beat: beat 0 still uses the old coef[0]
    writeCoef(0, 2);
    for (int n = 1; n < 9; n++) writeCoef(n, 1);
    bus.k_we     = 1'b1;
    bus.k_addr   = 4'd0;
    bus.k_data   = 6'd5;
    bus.in_valid = 1'b1;
    bus.in_data  = 6'd3;
    tick();
    bus.k_we     = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("samecyc_k_err", 32'(bus.k_err), 0);
    for (int n = 1; n < 9; n++) applyStimulus(1);
    finishWindow("samecyc_old", 14);
    for (int n = 0; n < 9; n++) applyStimulus(1);
    finishWindow("samecyc_new", 13);

    // Reset mid-window discards the partial sum and clears the coefficients
    writeCoef(0, 1);
    for (int n = 0; n < 4; n++) applyStimulus(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(bus.busy), 0);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 1);
    for (int n = 0; n < 9; n++) begin
      if (n == 8) checkOutput("midrst_early_valid", 32'(bus.out_valid), 0);
      applyStimulus(1);
    end
    finishWindow("midrst_zero", 0);

    // Reset while a sum is pending drops it
    for (int n = 0; n < 9; n++) writeCoef(n, n + 1);
    for (int n = 0; n < 9; n++) applyStimulus(n + 1);
    checkOutput("donerst_pending", 32'(bus.out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("donerst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("donerst_out_data", 32'(bus.out_data), 0);
    checkOutput("donerst_busy", 32'(bus.busy), 0);

    // Reset outranks a simultaneous kernel write and pixel beat
    rst          = 1'b1;
    bus.k_we     = 1'b1;
    bus.k_addr   = 4'd0;
    bus.k_data   = 6'd7;
    bus.in_valid = 1'b1;
    bus.in_data  = 6'd9;
    tick();
    rst = 1'b0;
    idleInputs();
    checkOutput("rstprio_busy", 32'(bus.busy), 0);
    checkOutput("rstprio_k_err", 32'(bus.k_err), 0);
    for (int n = 0; n < 9; n++) applyStimulus(1);
    finishWindow("rstprio_sum", 0);

    // 5x5 8-bit instance against a reference sum over 100 windows
    for (int w = 0; w < 100; w++) begin
      if (w % 10 == 0) begin
        for (int n = 0; n < BTAPS; n++) begin
          bcoef[n]       = $urandom_range(0, 255);
          big_bus.k_we   = 1'b1;
          big_bus.k_addr = 5'(n);
          big_bus.k_data = 8'(bcoef[n]);
          tick();
        end
        big_bus.k_we = 1'b0;
      end
      bexp = 0;
      for (int n = 0; n < BTAPS; n++) begin
        if ($urandom_range(0, 3) == 0) tick();
        bpix             = $urandom_range(0, 255);
        bexp             = bexp + bpix * bcoef[n];
        big_bus.in_valid = 1'b1;
        big_bus.in_data  = 8'(bpix);
        tick();
        big_bus.in_valid = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
      checkOutput($sformatf("big_w%0d_valid", w), 32'(big_bus.out_valid), 1);
      checkOutput($sformatf("big_w%0d_sum", w), 32'(big_bus.out_data), bexp % (32'd1 << BACC_W));
      big_bus.out_ready = 1'b1;
      tick();
      big_bus.out_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/conv_mac_stream.md
CONV_MAC_STREAM -- requirements
Module: conv_mac_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 6, pixel and kernel coefficient width in bits (unsigned).
REQ-002 SHALL have parameter TAPS, default 9, products per window (9 = 3x3, 25 = 5x5); legal range 2..64.
REQ-003 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(TAPS), accumulator and output width.
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port k_we, input, 1, kernel coefficient write strobe.
REQ-007 SHALL have port k_addr, input, $clog2(TAPS), coefficient index.
REQ-008 SHALL have port k_data, input, DATA_W, coefficient value.
REQ-009 SHALL have port k_err, output, 1, one-cycle pulse when a kernel write is rejected.
REQ-010 SHALL have port in_valid, input, 1, pixel beat valid.
REQ-011 SHALL have port in_ready, output, 1, block accepts pixel beat.
REQ-012 SHALL have port in_data, input, DATA_W, pixel value; beat n of a window pairs with coefficient n.
REQ-013 SHALL have port out_valid, input-independent output, 1, window sum valid.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts sum.
REQ-015 SHALL have port out_data, output, ACC_W, window sum.
REQ-016 SHALL have port busy, output, 1, high in ACCUM or DONE.

Function
REQ-017 SHALL hold TAPS coefficient registers; write occurs at clk edge when k_we=1, state=IDLE and k_addr<TAPS.
REQ-018 SHALL reject writes when state!=IDLE or k_addr>=TAPS: coefficients unchanged, k_err=1 for the following cycle.
REQ-019 SHALL implement states IDLE, ACCUM, DONE.
REQ-020 SHALL accept a beat when in_valid&&in_ready; in_ready=1 in IDLE and ACCUM, 0 in DONE.
REQ-021 IDLE: on accepted beat, acc <= in_data*coef[0], tap_cnt <= 1, go ACCUM (TAPS>=2 guaranteed).
REQ-022 ACCUM: on accepted beat, acc <= acc + in_data*coef[tap_cnt], tap_cnt increments; no beat -> hold acc and tap_cnt.
REQ-023 ACCUM: beat with tap_cnt=TAPS-1 SHALL load final sum into out_data, tap_cnt <= 0, go DONE; out_valid=1 the next cycle (latency 1 cycle after last beat).
REQ-024 DONE: out_valid=1, out_data stable until out_valid&&out_ready; then go IDLE with out_valid=0 next cycle.
REQ-025 Products SHALL be full 2*DATA_W unsigned; accumulation SHALL be unsigned ACC_W, wrap modulo 2^ACC_W if ACC_W is set below default (no saturation).
REQ-026 A kernel write in the same cycle as the first beat in IDLE SHALL be accepted and take effect from the next beat; beat 0 uses the pre-write coef[0].
REQ-027 in_valid while in DONE SHALL be ignored (no acceptance, no state change).
REQ-028 busy SHALL equal (state!=IDLE).

Reset
REQ-029 rst=1 at a clk edge SHALL force state=IDLE, acc=0, tap_cnt=0, out_data=0, out_valid=0, k_err=0, coefficients=0; in_ready=1 from the next cycle.
REQ-030 rst mid-window or in DONE SHALL discard the partial/pending sum; no out_valid is produced for it.
REQ-031 rst SHALL take priority over k_we and in_valid in the same cycle.

Verification
REQ-032 DATA_W=6,TAPS=9: all coef=63, nine beats of 63 back-to-back -> out_valid one cycle after 9th beat, out_data=35721.
REQ-033 coef[n]=n+1, pixels 1..9 with in_valid gaps of 2 cycles -> out_data=285; tap_cnt holds during gaps.
REQ-034 hold out_ready=0 five cycles in DONE while driving in_valid=1 -> out_data constant, in_ready=0, no beat consumed; release -> IDLE next cycle.
REQ-035 k_we during ACCUM and k_we with k_addr=9 -> k_err pulse each, coefficients unchanged, window sum unaffected.
REQ-036 rst after 4 beats, then full window of 1s with coef=0 -> out_data=0 (coefficients cleared), no stale output.
REQ-037 TAPS=25, DATA_W=8 random coef/pixels, 100 windows -> out_data matches reference model sum each window.
